// File: rtl/delta_decode.sv
// Adaptive delta-modulation decoder: expands an 8-bit word of up/down bits into
// eight signed 8-bit samples, one per clock, with a step that doubles on repeats and halves on flips.
module delta_decode #(
  parameter int STEP_INIT = 1,
  parameter int STEP_MIN  = 1,
  parameter int STEP_MAX  = 16
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic [0:7]        encode,
  input  logic signed [7:0] delay,
  output logic signed [7:0] result,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state, state_nx;
  logic [0:7]        word;
  logic [2:0]        idx;
  logic [7:0]        step;
  logic              prev_bit;
  logic              fresh;     // next consumed bit is the first one after idle

  logic              cur_bit;
  logic              consume, latch, fin;
  logic [8:0]        step_dbl;
  logic [7:0]        step_half;
  logic [7:0]        step_nx;
  logic signed [8:0] sum;
  logic signed [7:0] sat;

  assign cur_bit   = word[idx];
  assign step_dbl  = {step, 1'b0};
  assign step_half = step >> 1;

  always_comb begin
    step_nx = step;
    if (fresh)
      step_nx = 8'(STEP_INIT);
    else if (cur_bit == prev_bit)
      step_nx = (step_dbl > 9'(STEP_MAX)) ? 8'(STEP_MAX) : step_dbl[7:0];
    else
      step_nx = (step_half < 8'(STEP_MIN)) ? 8'(STEP_MIN) : step_half;
  end

  // 9-bit sum cannot overflow; saturate whenever bits 8 and 7 disagree
  always_comb begin
    if (cur_bit)
      sum = {delay[7], delay} + $signed({1'b0, step_nx});
    else
      sum = {delay[7], delay} - $signed({1'b0, step_nx});
    if (sum[8] != sum[7])
      sat = sum[8] ? 8'sh80 : 8'sh7f;
    else
      sat = sum[7:0];
  end

  always_comb begin
    state_nx = state;
    consume  = 1'b0;
    latch    = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch    = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        consume  = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        consume = 1'b1;
        if (idx == 3'd7) begin
          fin = 1'b1;
          if (start) begin
            latch    = 1'b1;
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word     <= '0;
      idx      <= '0;
      step     <= 8'(STEP_INIT);
      prev_bit <= 1'b0;
      fresh    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= fin;
      if (consume) begin
        result   <= sat;
        step     <= step_nx;
        prev_bit <= cur_bit;
        idx      <= idx + 3'd1;
        fresh    <= 1'b0;
      end
      // a back-to-back reload keeps step/prev_bit so adaptation spans words
      if (latch) begin
        word  <= encode;
        idx   <= '0;
        busy  <= 1'b1;
        fresh <= (state == IDLE);
      end
      if (fin && !start) begin
        busy <= 1'b0;
        step <= 8'(STEP_INIT);
      end
    end
  end

endmodule

// File: tb/tb_delta_decode.sv
// Scoreboard bench for delta_decode: stimulus pushes hand-computed samples,
// a monitor pops one per output-producing edge (busy high before the edge).
module tb_delta_decode;

  logic              clk;
  logic              reset;
  logic              start;
  logic [0:7]        encode;
  logic signed [7:0] delay;
  logic signed [7:0] result;
  logic              busy;
  logic              done;
  logic              fb;

  typedef struct {
    int res;
    bit dn;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   held;

  delta_decode #(.STEP_INIT(1), .STEP_MIN(1), .STEP_MAX(16)) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .start    (start),
    .encode   (encode),
    .delay    (delay),
    .result   (result),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push8(input int v[8]);
    for (int i = 0; i < 8; i++) q.push_back('{v[i], (i == 7)});
  endtask

  // step to the next falling edge, refreshing the external sample memory
  task automatic nxt();
    @(negedge clk);
    if (fb) delay = result;
  endtask

  // monitor: an edge produces a sample exactly when busy was high before it
  initial begin
    logic b;
    exp_t e;
    forever begin
      @(posedge clk);
      b = busy;
      #1;
      if (b) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_sample: got result %0d with nothing expected (t=%0t)", result, $time);
        end else begin
          e = q.pop_front();
          chk("sample", int'(result), e.res);
          chk("done_pulse", int'(done), int'(e.dn));
        end
      end else begin
        chk("done_idle", int'(done), 0);
      end
    end
  end

  initial begin
    int w1[8]  = '{1, 3, 7, 5, 6, 5, 6, 5};
    int w2[8]  = '{6, 8, 12, 10, 11, 10, 11, 10};
    int sp[8]  = '{121, 122, 124, 127, 127, 127, 127, 127};
    int sn[8]  = '{-121, -122, -124, -128, -128, -128, -128, -128};
    reset  = 1'b1;
    start  = 1'b0;
    encode = '0;
    delay  = '0;
    fb     = 1'b0;

    #12;
    chk("reset_result", int'(result), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    nxt();

    // two back-to-back words with feedback, adaptation carried across
    nxt();
    fb = 1'b1; delay = result; encode = 8'b11101010; start = 1'b1;
    push8(w1);
    push8(w2);
    repeat (9) nxt();
    start = 1'b0;
    repeat (11) nxt();
    chk("idle_busy_cont", int'(busy), 0);
    chk("idle_result_cont", int'(result), 10);
    held = int'(result);
    repeat (2) nxt();
    chk("idle_hold_cont", int'(result), held);

    // positive saturation, single-cycle start pulse
    nxt();
    fb = 1'b0; delay = 8'sd120; encode = 8'hFF; start = 1'b1;
    push8(sp);
    nxt();
    start = 1'b0;
    repeat (10) nxt();
    chk("idle_busy_sat", int'(busy), 0);
    chk("idle_result_sat", int'(result), 127);

    // negative saturation
    nxt();
    delay = -8'sd120; encode = 8'h00; start = 1'b1;
    push8(sn);
    nxt();
    start = 1'b0;
    repeat (10) nxt();
    chk("idle_busy_neg", int'(busy), 0);
    chk("idle_result_neg", int'(result), -128);

    // async reset after the third bit of a word
    nxt();
    fb = 1'b1; delay = result; encode = 8'b11101010; start = 1'b1;
    q.push_back('{-127, 1'b0});
    q.push_back('{-125, 1'b0});
    q.push_back('{-121, 1'b0});
    nxt();
    start = 1'b0;
    repeat (3) nxt();
    reset = 1'b1;
    #1;
    chk("async_rst_result", int'(result), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    nxt();
    reset = 1'b0; start = 1'b1; delay = result;
    push8(w1);
    nxt();
    start = 1'b0;
    repeat (10) nxt();
    chk("idle_busy_rst", int'(busy), 0);
    chk("idle_result_rst", int'(result), 5);
    held = int'(result);
    repeat (3) nxt();
    chk("idle_hold_rst", int'(result), held);

    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
